// File: rtl/result_pkt_tx_if.sv
// Row-result handshake in, formatted-packet handshake out.
interface result_pkt_tx_if #(
  parameter int WIDTH_PKT = 32
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_row;
  logic [15:0]          in_sum;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_PKT-1:0] out_pkt;

  modport master (
    output in_valid, in_row, in_sum, out_ready,
    input  in_ready, out_valid, out_pkt
  );

  modport slave (
    input  in_valid, in_row, in_sum, out_ready,
    output in_ready, out_valid, out_pkt
  );
endinterface

// File: rtl/result_pkt_tx.sv
// Formats row sums into packets, buffers them and tracks 441-packet frames; one-cycle latency.
// Backpressure: in_ready drops only when the buffer is full; out_pkt holds while out_ready is low.
module result_pkt_tx #(
  parameter int WIDTH_DATA = 13,
  parameter int WIDTH_PKT  = 32,
  parameter int DEPTH_R    = 21,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  result_pkt_tx_if.slave   bus,
  output logic             frame_done,
  output logic [7:0]       frame_cnt,
  output logic             err_row,
  output logic             err_over
);

  localparam int             AW         = $clog2(FIFO_DEPTH);
  localparam int             FRAME_PKTS = DEPTH_R * DEPTH_R;
  localparam logic [8:0]     LAST_PKT   = 9'(FRAME_PKTS - 1);
  localparam logic [4:0]     ROW_MAX    = 5'(DEPTH_R);
  localparam logic [AW:0]    CNT_FULL   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]    CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0]  PTR_ONE    = AW'(1);

  typedef struct packed {
    logic [WIDTH_PKT-22:0]   rsvd_hi;
    logic [4:0]              row;
    logic [15-WIDTH_DATA:0]  rsvd_lo;
    logic [WIDTH_DATA-1:0]   data;
  } pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  pkt_t            mem_q [FIFO_DEPTH];
  pkt_t            mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [4:0]      row_cnt_q [DEPTH_R];
  logic [4:0]      row_cnt_d [DEPTH_R];
  logic [8:0]      pkt_cnt_q, pkt_cnt_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            err_row_q, err_row_d;
  logic            err_over_q, err_over_d;

  logic            fifo_full;
  logic            fifo_empty;
  logic            in_acc;
  logic            out_acc;
  logic            row_ok;
  logic            row_over;
  logic            push;
  logic            frame_end;
  logic [4:0]      row_idx;
  logic [4:0]      row_base;
  pkt_t            in_pkt;

  // Handshake, formatting and drop decisions.
  always_comb begin
    fifo_full  = (count_q == CNT_FULL);
    fifo_empty = (count_q == '0);

    bus.in_ready  = !rst && !fifo_full;
    bus.out_valid = !fifo_empty;
    bus.out_pkt   = fifo_empty ? '0 : mem_q[rd_ptr_q];

    in_acc    = bus.in_valid && bus.in_ready;
    out_acc   = bus.out_valid && bus.out_ready;
    frame_end = out_acc && (pkt_cnt_q == LAST_PKT);

    row_ok  = (bus.in_row < ROW_MAX);
    row_idx = row_ok ? bus.in_row : '0;
    // A frame-end clear lands before the beat, so the beat sees a fresh count.
    row_base = frame_end ? '0 : row_cnt_q[row_idx];
    row_over = (row_base == ROW_MAX);
    push     = in_acc && row_ok && !row_over;

    in_pkt     = '0;
    in_pkt.row = bus.in_row;
    if (|bus.in_sum[15:WIDTH_DATA]) begin
      in_pkt.data = '1;
    end else begin
      in_pkt.data = bus.in_sum[WIDTH_DATA-1:0];
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_pkt;
    end

    wr_ptr_d = push    ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = out_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    if (push && !out_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && out_acc) begin
      count_d = count_q - CNT_ONE;
    end

    for (int r = 0; r < DEPTH_R; r++) begin
      row_cnt_d[r] = frame_end ? '0 : row_cnt_q[r];
    end
    if (push) begin
      row_cnt_d[row_idx] = row_base + 5'd1;
    end

    pkt_cnt_d = pkt_cnt_q;
    if (frame_end) begin
      pkt_cnt_d = '0;
    end else if (out_acc) begin
      pkt_cnt_d = pkt_cnt_q + 9'd1;
    end

    frame_cnt_d = frame_cnt_q + {7'd0, frame_end};
    err_row_d   = err_row_q  || (in_acc && !row_ok);
    err_over_d  = err_over_q || (in_acc && row_ok && row_over);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (count_d != '0) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          state_d = ST_DONE;
        end else if ((count_d == '0) && (pkt_cnt_d == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = (count_d != '0) ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    frame_done = (state_q == ST_DONE);
    frame_cnt  = frame_cnt_q;
    err_row    = err_row_q;
    err_over   = err_over_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_cnt_q   <= '0;
      frame_cnt_q <= '0;
      err_row_q   <= 1'b0;
      err_over_q  <= 1'b0;
      for (int r = 0; r < DEPTH_R; r++) begin
        row_cnt_q[r] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_cnt_q   <= pkt_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_row_q   <= err_row_d;
      err_over_q  <= err_over_d;
      for (int r = 0; r < DEPTH_R; r++) begin
        row_cnt_q[r] <= row_cnt_d[r];
      end
    end
  end

  // Storage needs no reset: out_pkt is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    for (int e = 0; e < FIFO_DEPTH; e++) begin
      mem_q[e] <= mem_d[e];
    end
  end

endmodule

// File: tb/tb_result_pkt_tx.sv
// Bench for result_pkt_tx: fixed vectors, directed corner sequences and randomized frames
// checked every cycle against a queue-based reference model.
module tb_result_pkt_tx;

  localparam int NROW  = 21;
  localparam int NPKT  = NROW * NROW;
  localparam int LIMIT = 20000;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_done;
  logic [7:0] frame_cnt;
  logic       err_row;
  logic       err_over;

  result_pkt_tx_if #(.WIDTH_PKT(32)) bus ();

  result_pkt_tx #(
    .WIDTH_DATA(13),
    .WIDTH_PKT (32),
    .DEPTH_R   (21),
    .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt),
    .err_row   (err_row),
    .err_over  (err_over)
  );

  always #5 clk = ~clk;

  int          n_tot = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  logic [31:0] mq [$];
  int          m_rows [NROW];
  int          m_pkts;
  int          m_frames;
  bit          m_err_row;
  bit          m_err_over;
  bit          m_done;
  int          done_pulses = 0;

  typedef struct {
    logic [4:0]  row;
    logic [15:0] sum;
    logic [31:0] pkt;
  } vec_t;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [4:0] row, input logic [15:0] sum);
    logic [12:0] d;
    d = (sum > 16'd8191) ? 13'h1FFF : sum[12:0];
    return {11'd0, row, 3'd0, d};
  endfunction

  // Reference model: expected packets are a queue; rows, frames and errors are plain counters.
  always @(negedge clk) begin : monitor
    bit acc;
    bit pop;
    bit done_nxt;
    if (chk_en) begin
      chk1("in_ready", bus.in_ready, !rst && (mq.size() < 8));
      chk1("out_valid", bus.out_valid, mq.size() != 0);
      if (mq.size() != 0) chk32("out_pkt", bus.out_pkt, mq[0]);
      chk1("frame_done", frame_done, m_done);
      chk32("frame_cnt", 32'(frame_cnt), 32'(m_frames));
      chk1("err_row", err_row, m_err_row);
      chk1("err_over", err_over, m_err_over);
      if (frame_done) done_pulses++;
    end
    done_nxt = 1'b0;
    if (rst) begin
      mq.delete();
      for (int r = 0; r < NROW; r++) m_rows[r] = 0;
      m_pkts     = 0;
      m_frames   = 0;
      m_err_row  = 1'b0;
      m_err_over = 1'b0;
      chk_en     = 1'b1;
    end else if (chk_en) begin
      pop = (mq.size() != 0) && bus.out_ready;
      acc = bus.in_valid && (mq.size() < 8);
      if (pop) begin
        void'(mq.pop_front());
        m_pkts++;
        if (m_pkts == NPKT) begin
          m_pkts = 0;
          for (int r = 0; r < NROW; r++) m_rows[r] = 0;
          m_frames = (m_frames + 1) % 256;
          done_nxt = 1'b1;
        end
      end
      if (acc) begin
        if (int'(bus.in_row) >= NROW) begin
          m_err_row = 1'b1;
        end else if (m_rows[int'(bus.in_row)] == NROW) begin
          m_err_over = 1'b1;
        end else begin
          m_rows[int'(bus.in_row)]++;
          mq.push_back(fmt(bus.in_row, bus.in_sum));
        end
      end
    end
    m_done = done_nxt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    step();
    rst = 1'b0;
  endtask

  // One full frame: every row 21 times in shuffled order, random gaps and backpressure.
  task automatic send_frame();
    logic [4:0] lst [NPKT];
    logic [4:0] t;
    int         j;
    int         i   = 0;
    int         cyc = 0;
    for (int k = 0; k < NPKT; k++) lst[k] = 5'(k / NROW);
    for (int k = NPKT - 1; k > 0; k--) begin
      j      = int'($urandom_range(0, k));
      t      = lst[k];
      lst[k] = lst[j];
      lst[j] = t;
    end
    while (((i < NPKT) || (mq.size() != 0)) && (cyc < LIMIT)) begin
      bus.in_valid  = (i < NPKT) && ($urandom_range(0, 3) != 0);
      bus.in_row    = lst[(i < NPKT) ? i : 0];
      bus.in_sum    = 16'($urandom_range(0, 16383));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) i++;
      step();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk1("frame_no_timeout", cyc < LIMIT, 1'b1);
    repeat (3) step();
  endtask

  initial begin : watchdog
    #2ms;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vt [8];
    int   base;
    vt[0] = '{5'd3,  16'd100,   32'h00030064};
    vt[1] = '{5'd20, 16'd9000,  32'h00141FFF};
    vt[2] = '{5'd0,  16'd0,     32'h00000000};
    vt[3] = '{5'd0,  16'd8191,  32'h00001FFF};
    vt[4] = '{5'd1,  16'd8192,  32'h00011FFF};
    vt[5] = '{5'd7,  16'd65535, 32'h00071FFF};
    vt[6] = '{5'd10, 16'd4096,  32'h000A1000};
    vt[7] = '{5'd20, 16'd8190,  32'h00141FFE};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;

    // Reset state, then in_ready in the first cycle after release.
    step();
    @(negedge clk);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk32("rst_out_pkt", bus.out_pkt, 32'h0);
    chk1("rst_frame_done", frame_done, 1'b0);
    chk32("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    chk1("rst_err_row", err_row, 1'b0);
    chk1("rst_err_over", err_over, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_in_ready", bus.in_ready, 1'b1);
    step();

    // Single-beat vectors: packet appears one cycle after acceptance, then the output empties.
    for (int v = 0; v < 8; v++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_row    = vt[v].row;
      bus.in_sum    = vt[v].sum;
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk1("vec_valid", bus.out_valid, 1'b1);
      chk32("vec_pkt", bus.out_pkt, vt[v].pkt);
      step();
      @(negedge clk);
      chk1("vec_empty_after", bus.out_valid, 1'b0);
      step();
    end

    // Out-of-range row is swallowed and flagged.
    bus.in_valid = 1'b1;
    bus.in_row   = 5'd21;
    bus.in_sum   = 16'd5;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk1("bad_row_no_pkt", bus.out_valid, 1'b0);
    chk1("bad_row_err", err_row, 1'b1);
    step();

    // 22 beats to row 5: the last is dropped and flags overflow.
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_row    = 5'd5;
    for (int k = 0; k < 22; k++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = 16'(k * 7);
      if (k == 21) begin
        @(negedge clk);
        chk1("over_before_22nd", err_over, 1'b0);
      end
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk1("over_after_22nd", err_over, 1'b1);
    repeat (3) step();

    // Fill with out_ready low: 8 accepted, 9th refused, head held, then in-order drain.
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.in_valid = 1'b1;
      bus.in_row   = 5'(k);
      bus.in_sum   = 16'(k * 100 + 1);
      @(negedge clk);
      chk1("fill_in_ready", bus.in_ready, k < 8);
      step();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk32("hold_pkt", bus.out_pkt, fmt(5'd0, 16'd1));
      step();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk32("drain_pkt", bus.out_pkt, fmt(5'(k), 16'(k * 100 + 1)));
      step();
    end
    @(negedge clk);
    chk1("drain_empty", bus.out_valid, 1'b0);
    step();

    // Two randomized frames.
    do_reset();
    base = done_pulses;
    send_frame();
    chk32("frame1_cnt", 32'(frame_cnt), 32'd1);
    chk32("frame1_pulses", 32'(done_pulses - base), 32'd1);
    chk1("frame1_err_row", err_row, 1'b0);
    chk1("frame1_err_over", err_over, 1'b0);
    send_frame();
    chk32("frame2_cnt", 32'(frame_cnt), 32'd2);
    chk32("frame2_pulses", 32'(done_pulses - base), 32'd2);

    // Reset mid-frame after 100 packets out and 4 buffered.
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      bus.in_valid = 1'b1;
      bus.in_row   = 5'(k % NROW);
      bus.in_sum   = 16'(k);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_row   = 5'(k);
      bus.in_sum   = 16'(k + 500);
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk1("mid_buffered_valid", bus.out_valid, 1'b1);
    step();
    do_reset();
    @(negedge clk);
    chk1("mid_rst_flushed", bus.out_valid, 1'b0);
    step();
    base = done_pulses;
    send_frame();
    chk32("mid_frame_cnt", 32'(frame_cnt), 32'd1);
    chk32("mid_frame_pulses", 32'(done_pulses - base), 32'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
